// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous scene scheduler: holds a scene for N frames, then blanks for
// M frames before switching. Define SCENE_SHUFFLE_EN for LFSR-driven auto targets.
module vga_scene_sequencer #(
  parameter int V_ACTIVE     = 480,
  parameter int NUM_SCENES   = 4,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLANK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       auto_en,
  input  logic       pause,
  input  logic [1:0] manual_sel,
  input  logic       next_req,
  output logic [1:0] scene_sel,
  output logic       blank,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  localparam logic [9:0] V_ROW      = 10'(V_ACTIVE);
  localparam logic [1:0] LAST_SCENE = 2'(NUM_SCENES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES - 1);

  logic [0:0] state_reg, state_next;
  logic [1:0] scene_reg, scene_next;
  logic [1:0] target_reg, target_next;
  logic       blank_reg, blank_next;
  logic       tick_reg, tick_next;
  logic       boundary_reg;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0] hold_reg, hold_next;
  logic [3:0] blank_cnt_reg, blank_cnt_next;
  logic       pend_reg, pend_next;

  logic       boundary;
  logic       start;
  logic       manual_ok;
  logic [1:0] scene_inc;
  logic [1:0] auto_target;

  assign boundary  = (row == V_ROW) && (col == 10'd0);
  assign scene_inc = (scene_reg == LAST_SCENE) ? 2'd0 : scene_reg + 2'd1;
  assign manual_ok = (manual_sel != scene_reg) && (int'(manual_sel) < NUM_SCENES);

`ifdef SCENE_SHUFFLE_EN
  logic [7:0] lfsr_reg;
  logic [1:0] candidate;

  assign candidate = 2'(int'(lfsr_reg[1:0]) % NUM_SCENES);
  // Never pick the scene already on screen, otherwise the blank would be wasted.
  assign auto_target = (candidate != scene_reg) ? candidate :
                       (candidate == LAST_SCENE) ? 2'd0 : candidate + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_reg <= 8'h01;
    end else if (tick_reg) begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end
`else
  assign auto_target = scene_inc;
`endif

  always_comb begin
    state_next     = state_reg;
    scene_next     = scene_reg;
    target_next    = target_reg;
    blank_next     = blank_reg;
    hold_next      = hold_reg;
    blank_cnt_next = blank_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    start          = 1'b0;
    // Edge-qualified so a stalled raster cannot emit a second pulse.
    tick_next      = boundary && !boundary_reg;

    if (tick_reg) begin
      frame_cnt_next = frame_cnt_reg + 8'd1;
      case (state_reg)
        ST_SHOW: begin
          if (auto_en && pend_reg) begin
            start       = 1'b1;
            target_next = auto_target;
          end else if (!auto_en && manual_ok) begin
            start       = 1'b1;
            target_next = manual_sel;
          end else if (auto_en && !pause && hold_reg == HOLD_LAST) begin
            start       = 1'b1;
            target_next = auto_target;
          end else if (auto_en && !pause) begin
            hold_next = hold_reg + 8'd1;
          end else if (!auto_en) begin
            hold_next = 8'd0;
          end

          if (start) begin
            state_next     = ST_BLANK;
            blank_next     = 1'b1;
            blank_cnt_next = 4'd0;
            hold_next      = 8'd0;
          end
        end
        ST_BLANK: begin
          if (blank_cnt_reg == BLANK_LAST) begin
            scene_next     = target_reg;
            blank_next     = 1'b0;
            blank_cnt_next = 4'd0;
            state_next     = ST_SHOW;
          end else begin
            blank_cnt_next = blank_cnt_reg + 4'd1;
          end
        end
        default: begin
          state_next = ST_SHOW;
          blank_next = 1'b0;
        end
      endcase
    end

    // A skip request arriving on the same edge a transition starts is absorbed by it.
    if (start) begin
      pend_next = 1'b0;
    end else if (next_req && auto_en) begin
      pend_next = 1'b1;
    end else begin
      pend_next = pend_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_SHOW;
      scene_reg     <= 2'd0;
      target_reg    <= 2'd0;
      blank_reg     <= 1'b0;
      tick_reg      <= 1'b0;
      boundary_reg  <= 1'b0;
      frame_cnt_reg <= 8'd0;
      hold_reg      <= 8'd0;
      blank_cnt_reg <= 4'd0;
      pend_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      scene_reg     <= scene_next;
      target_reg    <= target_next;
      blank_reg     <= blank_next;
      tick_reg      <= tick_next;
      boundary_reg  <= boundary;
      frame_cnt_reg <= frame_cnt_next;
      hold_reg      <= hold_next;
      blank_cnt_reg <= blank_cnt_next;
      pend_reg      <= pend_next;
    end
  end

  assign scene_sel  = scene_reg;
  assign blank      = blank_reg;
  assign frame_tick = tick_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Directed bench for vga_scene_sequencer on a shrunken 8x8 raster (frame boundary at row 6).
module tb_vga_scene_sequencer;

  localparam int V_ACT = 6;
  localparam int H_TOT = 8;
  localparam int V_TOT = 8;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] row = 10'd0;
  logic [9:0] col = 10'd0;
  logic       auto_en = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] manual_sel = 2'd0;
  logic       next_req = 1'b0;
  logic [1:0] scene_sel;
  logic       blank;
  logic       frame_tick;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  vga_scene_sequencer #(
    .V_ACTIVE(V_ACT),
    .NUM_SCENES(4),
    .HOLD_FRAMES(4),
    .BLANK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .auto_en(auto_en),
    .pause(pause),
    .manual_sel(manual_sel),
    .next_req(next_req),
    .scene_sel(scene_sel),
    .blank(blank),
    .frame_tick(frame_tick),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic       a_en;
    logic       p;
    logic [1:0] msel;
    logic       nreq;
    int         ticks;
    logic [1:0] exp_scene;
    logic       exp_blank;
  } vec_t;

  vec_t vecs[$];

  int   checks = 0;
  int   errors = 0;
  int   ticks_seen = 0;
  int   total_ticks = 0;
  int   tick_err = 0;
  int   r_pos = 0;
  int   c_pos = 0;
  logic pend_tick = 1'b0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // One clock: predict frame_tick from what the coming edge samples, then advance the raster.
  task automatic cyc();
    pend_tick = rst_n && (row == 10'(V_ACT)) && (col == 10'd0);
    @(negedge clk);
    if (frame_tick) ticks_seen++;
    if (frame_tick !== pend_tick) tick_err++;
    if (c_pos == H_TOT - 1) begin
      c_pos = 0;
      r_pos = (r_pos == V_TOT - 1) ? 0 : r_pos + 1;
    end else begin
      c_pos++;
    end
    row = 10'(r_pos);
    col = 10'(c_pos);
  endtask

  task automatic wait_ticks(input int n, input string name);
    int start;
    int budget;
    start  = ticks_seen;
    budget = (n + 2) * FRAME;
    while ((ticks_seen - start) < n && budget > 0) begin
      cyc();
      budget--;
    end
    check({name, "_tick_count"}, ticks_seen - start, n);
    cyc();
    cyc();
  endtask

  task automatic add(input logic a, input logic p, input logic [1:0] m, input logic nr,
                     input int t, input logic [1:0] s, input logic b);
    vec_t v;
    v.a_en = a; v.p = p; v.msel = m; v.nreq = nr;
    v.ticks = t; v.exp_scene = s; v.exp_blank = b;
    vecs.push_back(v);
  endtask

  initial begin
    int mark;
    int bound;

    // auto rotation, HOLD=4 BLANK=2
    add(1, 0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 6, 2, 0);
    add(1, 0, 0, 0, 6, 3, 0);
    add(1, 0, 0, 0, 6, 0, 0);
    // manual select, then a change during BLANK
    add(0, 0, 2, 0, 1, 0, 1);
    add(0, 0, 2, 0, 2, 2, 0);
    add(0, 0, 1, 0, 1, 2, 1);
    add(0, 0, 3, 0, 1, 2, 1);
    add(0, 0, 3, 0, 1, 1, 0);
    add(0, 0, 3, 0, 1, 1, 1);
    add(0, 0, 3, 0, 2, 3, 0);
    add(0, 0, 3, 0, 3, 3, 0);
    // pause freezes hold count at 2
    add(1, 0, 3, 0, 2, 3, 0);
    add(1, 1, 3, 0, 10, 3, 0);
    add(1, 0, 3, 0, 1, 3, 0);
    add(1, 0, 3, 0, 1, 3, 1);
    add(1, 0, 3, 0, 2, 0, 0);
    // next_req in auto, then dropped in manual
    add(1, 0, 3, 0, 1, 0, 0);
    add(1, 0, 3, 1, 1, 0, 1);
    add(1, 0, 3, 0, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 2, 1, 0);
    add(1, 0, 1, 0, 1, 1, 1);
    // next_req during BLANK takes effect on the first SHOW tick
    add(1, 0, 1, 1, 1, 1, 1);
    add(1, 0, 1, 0, 1, 2, 0);
    add(1, 0, 1, 0, 1, 2, 1);
    add(1, 0, 1, 0, 2, 3, 0);

    rst_n = 1'b0;
    cyc(); cyc(); cyc();
    check("reset_scene_sel", scene_sel, 0);
    check("reset_blank", blank, 0);
    check("reset_frame_tick", frame_tick, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      auto_en    = vecs[i].a_en;
      pause      = vecs[i].p;
      manual_sel = vecs[i].msel;
      mark       = tick_err;
      if (vecs[i].nreq) begin
        next_req = 1'b1;
        cyc();
        next_req = 1'b0;
      end
      wait_ticks(vecs[i].ticks, $sformatf("vec%0d", i));
      total_ticks += vecs[i].ticks;
      check($sformatf("vec%0d_scene_sel", i), scene_sel, vecs[i].exp_scene);
      check($sformatf("vec%0d_blank", i), blank, vecs[i].exp_blank);
      check($sformatf("vec%0d_frame_cnt", i), frame_cnt, total_ticks % 256);
      check($sformatf("vec%0d_tick_timing", i), tick_err - mark, 0);
      $display("vec %0d auto=%0b pause=%0b msel=%0d nreq=%0b ticks=%0d -> scene=%0d blank=%0b cnt=%0d",
               i, vecs[i].a_en, vecs[i].p, vecs[i].msel, vecs[i].nreq, vecs[i].ticks,
               scene_sel, blank, frame_cnt);
    end

    // frame counter wrap 255 -> 0
    auto_en = 1'b1;
    pause   = 1'b0;
    mark    = tick_err;
    wait_ticks(255 - total_ticks, "to255");
    total_ticks = 255;
    check("frame_cnt_255", frame_cnt, 255);
    wait_ticks(1, "wrap");
    check("frame_cnt_wrap", frame_cnt, 0);
    check("wrap_tick_timing", tick_err - mark, 0);
    $display("wrap frame_cnt=%0d", frame_cnt);

    // reset in the middle of a transition aborts it
    bound = 8 * FRAME;
    while (!blank && bound > 0) begin
      cyc();
      bound--;
    end
    check("reach_blank", blank, 1);
    rst_n = 1'b0;
    cyc(); cyc(); cyc();
    check("midblank_reset_scene_sel", scene_sel, 0);
    check("midblank_reset_blank", blank, 0);
    check("midblank_reset_frame_tick", frame_tick, 0);
    check("midblank_reset_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    wait_ticks(1, "post_reset");
    check("post_reset_blank", blank, 0);
    check("post_reset_scene_sel", scene_sel, 0);
    check("post_reset_frame_cnt", frame_cnt, 1);
    $display("reset abort scene=%0d blank=%0b cnt=%0d", scene_sel, blank, frame_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
